// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: walks 1..3 layers, fetching bias and weight rows per neuron,
// launching the MAC ALU and writing each result neuron. Optional softmax hand-off under FC_SOFTMAX_EN.
module fc_layer_sequencer #(
   parameter int MEM_ADDRESS_WIDTH = 10,
   parameter int LAYER_SZ          = 7,
   parameter int NUM_LAYERS        = 2,
   parameter int L0_IN             = 120,
   parameter int L0_OUT            = 84,
   parameter int L1_OUT            = 10,
   parameter int L2_OUT            = 10,
   parameter logic [MEM_ADDRESS_WIDTH-1:0] WEIGHT_BASE = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clk_en,
   input  logic                         CNN_ready,
   output logic                         o_DMA_read,
   output logic [MEM_ADDRESS_WIDTH-1:0] o_DMA_address,
   output logic [LAYER_SZ-1:0]          o_DMA_count,
   input  logic                         DMA_ready,
   output logic                         o_ALU_clear,
   output logic                         o_ALU_en,
   output logic [1:0]                   o_ALU_load,
   input  logic                         ALU_ready,
   output logic                         o_Neuron_en,
   output logic [1:0]                   o_Neuron_layer,
   output logic [LAYER_SZ-1:0]          o_Neuron_address,
   output logic [1:0]                   o_datasrc,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_softmax_start,
   input  logic                         softmax_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_BIAS_REQ, S_BIAS_WAIT, S_W_REQ, S_W_WAIT, S_VAL,
      S_ALU_WAIT, S_WRITE, S_FINISH, S_SOFTMAX, S_DONE
   } state_t;

   state_t                         r_state, w_state_nxt;
   logic [1:0]                     r_k, w_k_nxt;
   logic [LAYER_SZ-1:0]            r_n, w_n_nxt;
   logic [MEM_ADDRESS_WIDTH-1:0]   r_ptr, w_ptr_nxt;
   logic [LAYER_SZ-1:0]            w_in_k, w_out_k;
   logic [1:0]                     w_src_nxt, w_load_nxt;

   logic                           r_read, r_clear, r_alu_en, r_neuron_en, r_busy, r_done;
   logic [MEM_ADDRESS_WIDTH-1:0]   r_addr;
   logic [LAYER_SZ-1:0]            r_count, r_naddr;
   logic [1:0]                     r_load, r_src, r_nlayer;

   function automatic logic [LAYER_SZ-1:0] in_of(input logic [1:0] k);
      case (k)
         2'd0:    in_of = LAYER_SZ'(L0_IN);
         2'd1:    in_of = LAYER_SZ'(L0_OUT);
         default: in_of = LAYER_SZ'(L1_OUT);
      endcase
   endfunction

   function automatic logic [LAYER_SZ-1:0] out_of(input logic [1:0] k);
      case (k)
         2'd0:    out_of = LAYER_SZ'(L0_OUT);
         2'd1:    out_of = LAYER_SZ'(L1_OUT);
         default: out_of = LAYER_SZ'(L2_OUT);
      endcase
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_n_nxt     = r_n;
      w_ptr_nxt   = r_ptr;
      w_in_k      = in_of(r_k);
      w_out_k     = out_of(r_k);
      case (r_state)
         S_IDLE: begin
            if (CNN_ready) begin
               w_k_nxt     = '0;
               w_n_nxt     = '0;
               w_ptr_nxt   = WEIGHT_BASE;
               w_state_nxt = S_BIAS_REQ;
            end
         end
         S_BIAS_REQ:  w_state_nxt = S_BIAS_WAIT;
         S_BIAS_WAIT: begin
            if (DMA_ready) begin
               w_ptr_nxt   = r_ptr + MEM_ADDRESS_WIDTH'(1);
               w_state_nxt = S_W_REQ;
            end
         end
         S_W_REQ:     w_state_nxt = S_W_WAIT;
         S_W_WAIT: begin
            if (DMA_ready) begin
               w_ptr_nxt   = r_ptr + MEM_ADDRESS_WIDTH'(w_in_k);
               w_state_nxt = S_VAL;
            end
         end
         S_VAL:       w_state_nxt = S_ALU_WAIT;
         S_ALU_WAIT:  if (ALU_ready) w_state_nxt = S_WRITE;
         S_WRITE: begin
            if (r_n < (w_out_k - LAYER_SZ'(1))) begin
               w_n_nxt     = r_n + LAYER_SZ'(1);
               w_state_nxt = S_BIAS_REQ;
            end else if (r_k < 2'(NUM_LAYERS - 1)) begin
               w_k_nxt     = r_k + 2'd1;
               w_n_nxt     = '0;
               w_state_nxt = S_BIAS_REQ;
            end else begin
               w_state_nxt = S_FINISH;
            end
         end
`ifdef FC_SOFTMAX_EN
         S_FINISH:    w_state_nxt = S_SOFTMAX;
         S_SOFTMAX:   if (softmax_done) w_state_nxt = S_DONE;
`else
         S_FINISH:    w_state_nxt = S_DONE;
         S_SOFTMAX:   w_state_nxt = S_DONE;
`endif
         S_DONE:      if (!CNN_ready) w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // Operand routing follows the state being entered so it lines up with the registered strobes.
   always_comb begin
      w_src_nxt  = 2'd0;
      w_load_nxt = 2'd0;
      case (w_state_nxt)
         S_BIAS_REQ, S_BIAS_WAIT: begin
            w_src_nxt  = 2'd3;
            w_load_nxt = 2'd1;
         end
         S_W_REQ, S_W_WAIT: begin
            w_src_nxt  = 2'd3;
            w_load_nxt = 2'd2;
         end
         S_VAL, S_ALU_WAIT, S_WRITE, S_FINISH: w_src_nxt = w_k_nxt;
         S_SOFTMAX, S_DONE:                    w_src_nxt = 2'(NUM_LAYERS);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_n     <= '0;
         r_ptr   <= WEIGHT_BASE;
      end else if (clk_en) begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_n     <= w_n_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_read      <= 1'b0;
         r_clear     <= 1'b0;
         r_alu_en    <= 1'b0;
         r_neuron_en <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_addr      <= '0;
         r_count     <= '0;
         r_naddr     <= '0;
         r_nlayer    <= '0;
         r_load      <= '0;
         r_src       <= '0;
      end else if (clk_en) begin
         r_read      <= (w_state_nxt == S_BIAS_REQ) || (w_state_nxt == S_W_REQ);
         r_clear     <= (w_state_nxt == S_BIAS_REQ);
         r_alu_en    <= (w_state_nxt == S_VAL);
         r_neuron_en <= (w_state_nxt == S_WRITE);
         r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
         r_done      <= (w_state_nxt == S_DONE);
         r_load      <= w_load_nxt;
         r_src       <= w_src_nxt;
         if (w_state_nxt == S_BIAS_REQ) begin
            r_addr  <= w_ptr_nxt;
            r_count <= LAYER_SZ'(1);
         end else if (w_state_nxt == S_W_REQ) begin
            r_addr  <= w_ptr_nxt;
            r_count <= w_in_k;
         end
         if (w_state_nxt == S_WRITE) begin
            r_nlayer <= r_k + 2'd1;
            r_naddr  <= r_n;
         end
      end
   end

`ifdef FC_SOFTMAX_EN
   logic r_sm_start;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_sm_start <= 1'b0;
      else if (clk_en)
         r_sm_start <= (w_state_nxt == S_SOFTMAX) && (r_state != S_SOFTMAX);
   end
   assign o_softmax_start = r_sm_start & clk_en;
`else
   logic w_unused_softmax;
   assign w_unused_softmax = softmax_done;
   assign o_softmax_start  = 1'b0;
`endif

   // Strobes are gated so a frozen cycle never repeats them.
   assign o_DMA_read       = r_read & clk_en;
   assign o_ALU_clear      = r_clear & clk_en;
   assign o_ALU_en         = r_alu_en & clk_en;
   assign o_Neuron_en      = r_neuron_en & clk_en;
   assign o_DMA_address    = r_addr;
   assign o_DMA_count      = r_count;
   assign o_ALU_load       = r_load;
   assign o_Neuron_layer   = r_nlayer;
   assign o_Neuron_address = r_naddr;
   assign o_datasrc        = r_src;
   assign o_busy           = r_busy;
   assign o_done           = r_done;

endmodule
